// File: rtl/mpu6050_i2c_slave.sv
// ---------------------------------------------------------------------------
// mpu6050_i2c_slave
//
// Bit-level I2C responder that looks like an MPU6050 to an I2C master.
// Provides five writable configuration registers, read-only sensor registers
// fed from input ports, WHO_AM_I, and an auto-incrementing register pointer.
// Everything runs on one system clock. SCL and SDA are oversampled, so clk
// must run at least 20x faster than SCL.
//
// Ports
//   clk           system clock
//   rst           synchronous active-high reset
//   scl_in        raw SCL from the pad (asynchronous)
//   sda_in        raw SDA from the pad (asynchronous)
//   sda_oe        1 = pull SDA low (open-drain), 0 = release
//   acc_x/y/z     accelerometer words {H,L}, read at 0x3B..0x40
//   gyro_x/y/z    gyroscope words {H,L}, read at 0x43..0x48
//   smplrt_div    register 0x19
//   config_reg    register 0x1A ("config" is a reserved word, hence the suffix)
//   gyro_config   register 0x1B
//   accel_config  register 0x1C
//   pwr_mgmt_1    register 0x6B
//   wr_stb        one-clk pulse after every accepted write data byte
//   wr_addr       register address of that write, valid with wr_stb
//   busy          high from an addressed START until STOP
// ---------------------------------------------------------------------------
module mpu6050_i2c_slave #(
    parameter logic [6:0] DEV_ADDR     = 7'h68,
    parameter logic [7:0] WHO_AM_I_VAL = 8'h68
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        scl_in,
    input  logic        sda_in,
    output logic        sda_oe,
    input  logic [15:0] acc_x,
    input  logic [15:0] acc_y,
    input  logic [15:0] acc_z,
    input  logic [15:0] gyro_x,
    input  logic [15:0] gyro_y,
    input  logic [15:0] gyro_z,
    output logic [7:0]  smplrt_div,
    output logic [7:0]  config_reg,
    output logic [7:0]  gyro_config,
    output logic [7:0]  accel_config,
    output logic [7:0]  pwr_mgmt_1,
    output logic        wr_stb,
    output logic [6:0]  wr_addr,
    output logic        busy
);

    localparam logic [3:0] ST_IDLE      = 4'd0;
    localparam logic [3:0] ST_ADDR      = 4'd1;
    localparam logic [3:0] ST_ADDR_ACK  = 4'd2;
    localparam logic [3:0] ST_REG       = 4'd3;
    localparam logic [3:0] ST_REG_ACK   = 4'd4;
    localparam logic [3:0] ST_WDATA     = 4'd5;
    localparam logic [3:0] ST_WDATA_ACK = 4'd6;
    localparam logic [3:0] ST_RDATA     = 4'd7;
    localparam logic [3:0] ST_RDATA_ACK = 4'd8;
    localparam logic [3:0] ST_IGNORE    = 4'd9;

    localparam logic [7:0] PWR_RESET = 8'h40;

    logic       scl_s1, scl_s2, scl_h;
    logic       sda_s1, sda_s2, sda_h;
    logic       scl_rise, scl_fall, start_det, stop_det;

    logic [3:0] state;
    logic [3:0] bit_cnt;
    logic [7:0] shift_reg;
    logic [6:0] ptr;
    logic       rw;
    logic       master_nack;

    logic [15:0] snap_ax, snap_ay, snap_az, snap_gx, snap_gy, snap_gz;

    logic [6:0] rd_addr;
    logic [7:0] read_byte;

    // Two-stage synchronizer plus one history stage per line. Resetting to 1
    // matches an idle bus, so leaving reset never fakes a START or STOP.
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_s1 <= 1'b1;
            scl_s2 <= 1'b1;
            scl_h  <= 1'b1;
            sda_s1 <= 1'b1;
            sda_s2 <= 1'b1;
            sda_h  <= 1'b1;
        end else begin
            scl_s1 <= scl_in;
            scl_s2 <= scl_s1;
            scl_h  <= scl_s2;
            sda_s1 <= sda_in;
            sda_s2 <= sda_s1;
            sda_h  <= sda_s2;
        end
    end

    // START/STOP need SCL high on both the current and the previous sample,
    // so an SDA change at the same moment SCL falls is not a bus condition.
    assign scl_rise  =  scl_s2 & ~scl_h;
    assign scl_fall  = ~scl_s2 &  scl_h;
    assign start_det =  scl_s2 &  scl_h &  sda_h & ~sda_s2;
    assign stop_det  =  scl_s2 &  scl_h & ~sda_h &  sda_s2;

    // Read map. While waiting on the master's ACK the next byte is
    // prefetched from ptr+1, so it can be driven on the following SCL fall.
    always_comb begin
        rd_addr   = (state == ST_RDATA_ACK) ? ptr + 7'd1 : ptr;
        read_byte = 8'h00;
        case (rd_addr)
            7'h19:   read_byte = smplrt_div;
            7'h1A:   read_byte = config_reg;
            7'h1B:   read_byte = gyro_config;
            7'h1C:   read_byte = accel_config;
            7'h3B:   read_byte = snap_ax[15:8];
            7'h3C:   read_byte = snap_ax[7:0];
            7'h3D:   read_byte = snap_ay[15:8];
            7'h3E:   read_byte = snap_ay[7:0];
            7'h3F:   read_byte = snap_az[15:8];
            7'h40:   read_byte = snap_az[7:0];
            7'h43:   read_byte = snap_gx[15:8];
            7'h44:   read_byte = snap_gx[7:0];
            7'h45:   read_byte = snap_gy[15:8];
            7'h46:   read_byte = snap_gy[7:0];
            7'h47:   read_byte = snap_gz[15:8];
            7'h48:   read_byte = snap_gz[7:0];
            7'h6B:   read_byte = pwr_mgmt_1;
            7'h75:   read_byte = WHO_AM_I_VAL;
            default: read_byte = 8'h00;
        endcase
    end

    // Protocol engine. A STOP or START in any state wins over the byte in
    // progress, so a partially shifted write byte is simply dropped. All
    // sda_oe changes in the data phases happen on an SCL fall detect.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            bit_cnt      <= 4'd0;
            shift_reg    <= 8'h00;
            ptr          <= 7'h00;
            rw           <= 1'b0;
            master_nack  <= 1'b0;
            sda_oe       <= 1'b0;
            busy         <= 1'b0;
            wr_stb       <= 1'b0;
            wr_addr      <= 7'h00;
            smplrt_div   <= 8'h00;
            config_reg   <= 8'h00;
            gyro_config  <= 8'h00;
            accel_config <= 8'h00;
            pwr_mgmt_1   <= PWR_RESET;
            snap_ax      <= 16'h0000;
            snap_ay      <= 16'h0000;
            snap_az      <= 16'h0000;
            snap_gx      <= 16'h0000;
            snap_gy      <= 16'h0000;
            snap_gz      <= 16'h0000;
        end else begin
            wr_stb <= 1'b0;
            if (stop_det) begin
                state  <= ST_IDLE;
                sda_oe <= 1'b0;
                busy   <= 1'b0;
            end else if (start_det) begin
                state   <= ST_ADDR;
                sda_oe  <= 1'b0;
                bit_cnt <= 4'd0;
            end else begin
                case (state)
                    ST_ADDR: begin
                        if (scl_rise) begin
                            shift_reg <= {shift_reg[6:0], sda_s2};
                            bit_cnt   <= bit_cnt + 4'd1;
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            if (shift_reg[7:1] == DEV_ADDR) begin
                                busy   <= 1'b1;
                                rw     <= shift_reg[0];
                                sda_oe <= 1'b1;
                                state  <= ST_ADDR_ACK;
                                // Freeze the sensor words for the whole burst.
                                if (shift_reg[0]) begin
                                    snap_ax <= acc_x;
                                    snap_ay <= acc_y;
                                    snap_az <= acc_z;
                                    snap_gx <= gyro_x;
                                    snap_gy <= gyro_y;
                                    snap_gz <= gyro_z;
                                end
                            end else begin
                                state <= ST_IGNORE;
                            end
                        end
                    end
                    ST_ADDR_ACK: begin
                        if (scl_fall) begin
                            bit_cnt <= 4'd0;
                            if (rw) begin
                                shift_reg <= read_byte;
                                sda_oe    <= ~read_byte[7];
                                state     <= ST_RDATA;
                            end else begin
                                sda_oe <= 1'b0;
                                state  <= ST_REG;
                            end
                        end
                    end
                    ST_REG: begin
                        if (scl_rise) begin
                            shift_reg <= {shift_reg[6:0], sda_s2};
                            bit_cnt   <= bit_cnt + 4'd1;
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            ptr    <= shift_reg[6:0];
                            sda_oe <= 1'b1;
                            state  <= ST_REG_ACK;
                        end
                    end
                    ST_WDATA: begin
                        if (scl_rise) begin
                            shift_reg <= {shift_reg[6:0], sda_s2};
                            bit_cnt   <= bit_cnt + 4'd1;
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            wr_stb  <= 1'b1;
                            wr_addr <= ptr;
                            ptr     <= ptr + 7'd1;
                            sda_oe  <= 1'b1;
                            state   <= ST_WDATA_ACK;
                            case (ptr)
                                7'h19: smplrt_div   <= shift_reg;
                                7'h1A: config_reg   <= shift_reg;
                                7'h1B: gyro_config  <= shift_reg;
                                7'h1C: accel_config <= shift_reg;
                                7'h6B: begin
                                    // DEVICE_RESET (bit7) self-clears and
                                    // returns every config register to default.
                                    if (shift_reg[7]) begin
                                        smplrt_div   <= 8'h00;
                                        config_reg   <= 8'h00;
                                        gyro_config  <= 8'h00;
                                        accel_config <= 8'h00;
                                        pwr_mgmt_1   <= PWR_RESET;
                                    end else begin
                                        pwr_mgmt_1 <= {1'b0, shift_reg[6:0]};
                                    end
                                end
                                default: ;
                            endcase
                        end
                    end
                    ST_REG_ACK, ST_WDATA_ACK: begin
                        if (scl_fall) begin
                            sda_oe  <= 1'b0;
                            bit_cnt <= 4'd0;
                            state   <= ST_WDATA;
                        end
                    end
                    ST_RDATA: begin
                        if (scl_rise) begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall) begin
                            if (bit_cnt == 4'd8) begin
                                sda_oe <= 1'b0;
                                state  <= ST_RDATA_ACK;
                            end else begin
                                sda_oe    <= ~shift_reg[6];
                                shift_reg <= {shift_reg[6:0], 1'b0};
                            end
                        end
                    end
                    ST_RDATA_ACK: begin
                        if (scl_rise) begin
                            master_nack <= sda_s2;
                        end else if (scl_fall) begin
                            if (master_nack) begin
                                sda_oe <= 1'b0;
                                state  <= ST_IGNORE;
                            end else begin
                                ptr       <= ptr + 7'd1;
                                shift_reg <= read_byte;
                                sda_oe    <= ~read_byte[7];
                                bit_cnt   <= 4'd0;
                                state     <= ST_RDATA;
                            end
                        end
                    end
                    default: sda_oe <= 1'b0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mpu6050_i2c_slave.sv
// ---------------------------------------------------------------------------
// tb_mpu6050_i2c_slave
//
// Drives mpu6050_i2c_slave as an I2C master over an open-drain bus and
// compares every observable result with a register-map model of the device.
// ---------------------------------------------------------------------------
module tb_mpu6050_i2c_slave;

    localparam int Q = 100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m_scl = 1'b1;
    logic        m_sda = 1'b1;
    logic        sda_line;
    logic        sda_oe;
    logic [15:0] acc_x, acc_y, acc_z, gyro_x, gyro_y, gyro_z;
    logic [7:0]  smplrt_div, config_reg, gyro_config, accel_config, pwr_mgmt_1;
    logic        wr_stb;
    logic [6:0]  wr_addr;
    logic        busy;

    int compared   = 0;
    int mismatched = 0;

    logic [7:0]  mdl_cfg [0:127];
    int          mdl_ptr;
    logic [15:0] snap [0:6];
    logic [7:0]  wq [$];
    logic [6:0]  exp_stb [$];
    logic [6:0]  stb_log [$];
    logic        watch = 1'b0;
    logic        oe_seen = 1'b0;
    logic        busy_seen = 1'b0;

    assign sda_line = m_sda & ~sda_oe;

    always #5 clk = ~clk;

    mpu6050_i2c_slave dut (
        .clk          (clk),
        .rst          (rst),
        .scl_in       (m_scl),
        .sda_in       (sda_line),
        .sda_oe       (sda_oe),
        .acc_x        (acc_x),
        .acc_y        (acc_y),
        .acc_z        (acc_z),
        .gyro_x       (gyro_x),
        .gyro_y       (gyro_y),
        .gyro_z       (gyro_z),
        .smplrt_div   (smplrt_div),
        .config_reg   (config_reg),
        .gyro_config  (gyro_config),
        .accel_config (accel_config),
        .pwr_mgmt_1   (pwr_mgmt_1),
        .wr_stb       (wr_stb),
        .wr_addr      (wr_addr),
        .busy         (busy)
    );

    // Log every write strobe and watch the bus during unaddressed traffic.
    always @(negedge clk) begin
        if (wr_stb) stb_log.push_back(wr_addr);
        if (watch && sda_oe) oe_seen = 1'b1;
        if (watch && busy) busy_seen = 1'b1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit is_cfg(input int a);
        return (a == 'h19) || (a == 'h1A) || (a == 'h1B) || (a == 'h1C) || (a == 'h6B);
    endfunction

    task automatic model_reset_cfg();
        for (int i = 0; i < 128; i++) mdl_cfg[i] = 8'h00;
        mdl_cfg['h6B] = 8'h40;
    endtask

    task automatic model_write(input logic [7:0] d);
        if (is_cfg(mdl_ptr)) begin
            if (mdl_ptr == 'h6B && d[7]) model_reset_cfg();
            else if (mdl_ptr == 'h6B) mdl_cfg[mdl_ptr] = d & 8'h7F;
            else mdl_cfg[mdl_ptr] = d;
        end
        exp_stb.push_back(7'(mdl_ptr));
        mdl_ptr = (mdl_ptr + 1) % 128;
    endtask

    task automatic take_snapshot();
        snap[0] = acc_x;  snap[1] = acc_y;  snap[2] = acc_z;
        snap[3] = 16'h0000;
        snap[4] = gyro_x; snap[5] = gyro_y; snap[6] = gyro_z;
    endtask

    function automatic logic [7:0] model_read(input int a);
        int off;
        logic [15:0] w;
        if (a >= 'h3B && a <= 'h48) begin
            off = a - 'h3B;
            w = snap[off / 2];
            return (off % 2 == 0) ? w[15:8] : w[7:0];
        end
        if (is_cfg(a)) return mdl_cfg[a];
        if (a == 'h75) return 8'h68;
        return 8'h00;
    endfunction

    // ---------------- bus master ----------------
    task automatic i2c_start();
        m_sda = 1'b1; #Q; m_scl = 1'b1; #Q; m_sda = 1'b0; #Q; m_scl = 1'b0; #Q;
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; #Q; m_scl = 1'b1; #Q; m_sda = 1'b1; #Q;
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            m_sda = b[i]; #Q; m_scl = 1'b1; #(2*Q); m_scl = 1'b0; #Q;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        send_bits(b, 8);
        m_sda = 1'b1; #Q; m_scl = 1'b1; #Q; ack = sda_line; #Q; m_scl = 1'b0; #Q;
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] b);
        m_sda = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            #Q; m_scl = 1'b1; #Q; b[i] = sda_line; #Q; m_scl = 1'b0; #Q;
        end
        m_sda = nack; #Q; m_scl = 1'b1; #(2*Q); m_scl = 1'b0; #Q;
    endtask

    // ---------------- checks ----------------
    task automatic check_regs(input string tag);
        checkOutput({tag, "_smplrt_div"},   smplrt_div,   mdl_cfg['h19]);
        checkOutput({tag, "_config"},       config_reg,   mdl_cfg['h1A]);
        checkOutput({tag, "_gyro_config"},  gyro_config,  mdl_cfg['h1B]);
        checkOutput({tag, "_accel_config"}, accel_config, mdl_cfg['h1C]);
        checkOutput({tag, "_pwr_mgmt_1"},   pwr_mgmt_1,   mdl_cfg['h6B]);
    endtask

    task automatic check_strobes(input string tag);
        checkOutput({tag, "_stb_count"}, stb_log.size(), exp_stb.size());
        for (int i = 0; i < stb_log.size() && i < exp_stb.size(); i++)
            checkOutput({tag, "_stb_addr"}, stb_log[i], exp_stb[i]);
        stb_log.delete();
        exp_stb.delete();
    endtask

    // ---------------- transactions ----------------
    task automatic write_regs(input logic [6:0] reg_a);
        logic ack;
        i2c_start();
        send_byte(8'hD0, ack);
        checkOutput("wr_dev_ack", ack, 0);
        checkOutput("busy_on", busy, 1);
        send_byte({1'b0, reg_a}, ack);
        checkOutput("wr_reg_ack", ack, 0);
        mdl_ptr = reg_a;
        foreach (wq[i]) begin
            send_byte(wq[i], ack);
            checkOutput("wr_data_ack", ack, 0);
            model_write(wq[i]);
        end
        i2c_stop();
        checkOutput("busy_after_stop", busy, 0);
        check_regs("wr");
        check_strobes("wr");
    endtask

    task automatic read_regs(input logic [6:0] reg_a, input int n, input int change_after, input logic [15:0] new_acc_y);
        logic ack;
        logic [7:0] b;
        i2c_start();
        send_byte(8'hD0, ack);
        checkOutput("rd_dev_ack", ack, 0);
        send_byte({1'b0, reg_a}, ack);
        checkOutput("rd_reg_ack", ack, 0);
        mdl_ptr = reg_a;
        i2c_start();
        send_byte(8'hD1, ack);
        checkOutput("rd_devr_ack", ack, 0);
        take_snapshot();
        for (int i = 0; i < n; i++) begin
            read_byte(i == n - 1, b);
            checkOutput($sformatf("rd_%02h", mdl_ptr), b, model_read(mdl_ptr));
            if (i == change_after) acc_y = new_acc_y;
            if (i < n - 1) mdl_ptr = (mdl_ptr + 1) % 128;
        end
        checkOutput("oe_after_nack", sda_oe, 0);
        i2c_stop();
        checkOutput("busy_after_stop", busy, 0);
        check_strobes("rd");
    endtask

    task automatic applyStimulus();
        logic [6:0] start_a;
        int n;
        case ($urandom_range(0, 7))
            0: start_a = 7'h18;
            1: start_a = 7'h19;
            2: start_a = 7'h1A;
            3: start_a = 7'h1B;
            4: start_a = 7'h1C;
            5: start_a = 7'h6A;
            6: start_a = 7'h6B;
            default: start_a = 7'h74;
        endcase
        n = $urandom_range(1, 3);
        wq.delete();
        for (int i = 0; i < n; i++) wq.push_back(8'($urandom));
        acc_x  = 16'($urandom); acc_y  = 16'($urandom); acc_z  = 16'($urandom);
        gyro_x = 16'($urandom); gyro_y = 16'($urandom); gyro_z = 16'($urandom);
        write_regs(start_a);
        read_regs(start_a, n + 1, -1, 16'h0000);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic ack;
        acc_x = 16'h0; acc_y = 16'h0; acc_z = 16'h0;
        gyro_x = 16'h0; gyro_y = 16'h0; gyro_z = 16'h0;
        model_reset_cfg();
        mdl_ptr = 0;
        rst = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput("rst_sda_oe", sda_oe, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_wr_stb", wr_stb, 0);
        checkOutput("rst_wr_addr", wr_addr, 0);
        check_regs("rst");
        rst = 1'b0;
        repeat (4) @(negedge clk);

        $display("[TB] single write to PWR_MGMT_1");
        wq = '{8'h00};
        write_regs(7'h6B);

        $display("[TB] burst write 0x19..0x1C");
        wq = '{8'h07, 8'h06, 8'h18, 8'h01};
        write_regs(7'h19);

        $display("[TB] 14-byte sensor burst");
        acc_x = 16'h1234; acc_y = 16'h5678; acc_z = 16'h9ABC;
        gyro_x = 16'hDEF0; gyro_y = 16'h0F1E; gyro_z = 16'hBEEF;
        read_regs(7'h3B, 14, -1, 16'h0000);

        $display("[TB] snapshot coherence");
        acc_y = 16'h1111;
        read_regs(7'h3B, 4, 1, 16'h2222);
        read_regs(7'h3D, 2, -1, 16'h0000);

        $display("[TB] foreign address 0xD2");
        oe_seen = 1'b0; busy_seen = 1'b0; watch = 1'b1;
        i2c_start();
        send_byte(8'hD2, ack);
        checkOutput("d2_addr_nak", ack, 1);
        send_byte(8'h19, ack);
        checkOutput("d2_reg_nak", ack, 1);
        send_byte(8'hAA, ack);
        checkOutput("d2_data_nak", ack, 1);
        i2c_stop();
        watch = 1'b0;
        checkOutput("d2_oe_seen", oe_seen, 0);
        checkOutput("d2_busy_seen", busy_seen, 0);
        check_regs("d2");
        check_strobes("d2");

        $display("[TB] device reset via PWR_MGMT_1 bit7");
        wq = '{8'h18};
        write_regs(7'h1B);
        wq = '{8'h80};
        write_regs(7'h6B);
        checkOutput("devrst_gyro_config", gyro_config, 8'h00);
        checkOutput("devrst_pwr_mgmt_1", pwr_mgmt_1, 8'h40);

        $display("[TB] STOP after 4 data bits");
        i2c_start();
        send_byte(8'hD0, ack);
        checkOutput("abort_dev_ack", ack, 0);
        send_byte(8'h19, ack);
        checkOutput("abort_reg_ack", ack, 0);
        send_bits(8'hF0, 4);
        i2c_stop();
        checkOutput("abort_busy", busy, 0);
        check_regs("abort");
        check_strobes("abort");

        $display("[TB] randomized write/readback");
        for (int it = 0; it < 8; it++) applyStimulus();

        $display("[TB] pointer wrap 0x7F -> 0x00");
        wq = '{8'hAA, 8'hBB};
        write_regs(7'h7F);

        $display("[TB] reset during read");
        wq = '{8'h5A};
        write_regs(7'h1C);
        acc_x = 16'h0000;
        i2c_start();
        send_byte(8'hD0, ack);
        send_byte(8'h3B, ack);
        i2c_start();
        send_byte(8'hD1, ack);
        checkOutput("rr_dev_ack", ack, 0);
        checkOutput("rr_oe_drive", sda_oe, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        model_reset_cfg();
        mdl_ptr = 0;
        checkOutput("rr_sda_oe", sda_oe, 0);
        checkOutput("rr_busy", busy, 0);
        checkOutput("rr_wr_addr", wr_addr, 0);
        check_regs("rr");
        i2c_stop();
        stb_log.delete();
        exp_stb.delete();

        $display("[TB] WHO_AM_I");
        read_regs(7'h75, 1, -1, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mpu6050_i2c_slave.md
Name: mpu6050_i2c_slave

Overview:
- I2C responder (slave) that emulates the MPU6050 register interface at bit level on a single system clock.
- Lets the existing I2C master sequencer be exercised on-chip and in simulation without a physical sensor. It can also present FPGA-generated motion data to an external I2C master.
- Provides writable config registers, read-only sensor registers sourced from input ports, WHO_AM_I, and register-pointer auto-increment.

Parameters:
- DEV_ADDR, 7'h68, 7-bit slave address matched in the address byte.
- WHO_AM_I_VAL, 8'h68, value returned at register 0x75.

Ports:
- clk  in  1  system clock; frequency must be ≥ 20× SCL frequency.
- rst  in  1  reset; synchronous, active-high.
- scl_in  in  1  raw SCL from pad; asynchronous.
- sda_in  in  1  raw SDA from pad; asynchronous.
- sda_oe  out  1  1 = pull SDA low (open-drain); 0 = release.
- acc_x, acc_y, acc_z  in  16 each  accelerometer samples, {H,L}.
- gyro_x, gyro_y, gyro_z  in  16 each  gyroscope samples, {H,L}.
- smplrt_div, config, gyro_config, accel_config, pwr_mgmt_1  out  8 each  current contents of regs 0x19, 0x1A, 0x1B, 0x1C, 0x6B.
- wr_stb  out  1  one-clk pulse after any accepted register write byte.
- wr_addr  out  7  register address of the last write; valid while wr_stb is high.
- busy  out  1  high from an addressed START until STOP.

Behaviour:
- Input conditioning: scl_in and sda_in each pass through a 2-FF synchronizer plus one history FF. Edges are detected from synchronized vs history.
  - START = SDA falling while SCL high.
  - STOP = SDA rising while SCL high.
- Sampling and driving: sample SDA on the SCL rising-edge detect. Update sda_oe on the clk after the SCL falling-edge detect, i.e. within 4 clk of the raw edge.
- Reset values: sda_oe=0, busy=0, wr_stb=0, wr_addr=0, smplrt_div=0x00, config=0x00, gyro_config=0x00, accel_config=0x00, pwr_mgmt_1=0x40, reg pointer=0x00, state=IDLE.
- States and transitions:
  - IDLE: wait for START, then go to ADDR.
  - ADDR: shift in 8 bits.
    - If bits[7:1]==DEV_ADDR: go to ADDR_ACK; busy=1.
    - Otherwise: go to IGNORE; no ACK.
  - ADDR_ACK: drive low for the 9th SCL (from the falling edge after bit 8 to the falling edge after bit 9).
    - R/W=0: go to REG.
    - R/W=1: snapshot all six sensor words into a shadow register, load byte[ptr], go to RDATA.
  - REG: shift 8 bits; ptr = byte[6:0]; ACK; go to WDATA.
  - WDATA: shift 8 bits, then ACK.
    - If ptr ∈ {0x19, 0x1A, 0x1B, 0x1C, 0x6B}, update that register.
    - Other addresses: ACK, discard data.
    - Pulse wr_stb with wr_addr=ptr, then ptr++. Remain in WDATA for burst writes.
  - RDATA: drive the MSB first; sda_oe = ~bit. Release SDA for the 9th clock and sample the master ACK on its rising edge.
    - ACK (0): ptr++, load the next byte, continue.
    - NACK: release SDA, go to IGNORE.
  - IGNORE: sda_oe=0; wait for STOP or START.
- Read map:
  - 0x3B..0x40: acc X/Y/Z H,L.
  - 0x41..0x42: 0x00 (temperature not modelled).
  - 0x43..0x48: gyro X/Y/Z H,L.
  - Config registers read back their current value.
  - 0x75 returns WHO_AM_I_VAL.
  - All other addresses return 0x00.
- Snapshot coherence: every byte of one read burst comes from the snapshot taken at the address ACK. Input changes mid-burst are not visible until the next read transaction.
- Pointer: 7-bit; wraps 0x7F→0x00. It persists across STOP and repeated START, so write-reg then Sr+read reads from the written pointer.
- Device reset: writing pwr_mgmt_1 with bit7=1 restores all five config registers to their reset values on the next clk. Bit7 reads back as 0, so the stored value is 0x40.
- STOP or START in any state aborts the current byte immediately. A partial write byte is never committed.
  - STOP: sda_oe=0, busy=0, go to IDLE.
  - START: go to ADDR.
- rst during a transfer: all outputs return to reset values on the next clk; SDA is released.

Test Plan:
- Write 0xD0, 0x6B, 0x00, P.
  - Expect 3 ACKs, pwr_mgmt_1=0x00, and one wr_stb with wr_addr=0x6B.
- Burst write 0xD0, 0x19, 0x07, 0x06, 0x18, 0x01.
  - Expect smplrt_div=0x07, config=0x06, gyro_config=0x18, accel_config=0x01, and 4 wr_stb pulses.
- acc_x=0x1234, gyro_z=0xBEEF. Sequence: 0xD0, 0x3B, Sr, 0xD1, read 14 bytes with ACK and a final NACK.
  - Expect bytes 12 34 .. 00 00 .. BE EF in map order, with SDA released after the NACK.
- Change acc_y from 0x1111 to 0x2222 after reading byte 0x3C of an open burst.
  - Expect 0x3D/0x3E to return 11 11.
- Send address 0xD2.
  - Expect no ACK, sda_oe=0 throughout, busy=0, and registers unchanged.
- Write 0x80 to 0x6B after configuring 0x1B=0x18; also inject STOP after 4 data bits of a write.
  - Expect gyro_config=0x00 and pwr_mgmt_1=0x40; the aborted byte leaves its register unchanged.
